// File: rtl/tcb_lite_lib_misaligned_split.sv
// tcb_lite_lib_misaligned_split
// Byte-enable-mode TCB lite stage placed after an unaligned log-size to
// byte-enable converter. An access whose byte lanes wrap past the end of a
// data word is reissued as two word-aligned manager transfers, and the two
// read responses are merged back into one subordinate response. Accesses
// that stay inside one word pass straight through with no added latency.
//
// Optional build macro TCB_LITE_LIB_MISALIGNED_SPLIT_LCK_EN: when defined,
// the first piece of a split drives man lck=1 so that the pair stays atomic
// downstream. When undefined, both pieces carry the subordinate lck.
//
// The tcb_lite_if bundles are flattened into sub/man port groups; DLY, ADR
// and DAT are shared by both sides, so they cannot disagree.

module tcb_lite_lib_misaligned_split #(
  parameter  int unsigned DLY = 1,
  parameter  int unsigned ADR = 32,
  parameter  int unsigned DAT = 32,
  localparam int unsigned BYT = DAT / 8,
  localparam int unsigned MAX = $clog2(BYT),
  localparam int unsigned SIZ = $clog2(MAX + 1)
) (
  input  logic           clk,
  input  logic           rst,
  // subordinate side (upstream converter connects here)
  input  logic           i_sub_vld,
  output logic           o_sub_rdy,
  input  logic           i_sub_req_lck,
  input  logic           i_sub_req_ndn,
  input  logic           i_sub_req_wen,
  input  logic [ADR-1:0] i_sub_req_adr,
  input  logic [SIZ-1:0] i_sub_req_siz,
  input  logic [BYT-1:0] i_sub_req_byt,
  input  logic [DAT-1:0] i_sub_req_wdt,
  output logic [DAT-1:0] o_sub_rsp_rdt,
  output logic           o_sub_rsp_sts,
  output logic           o_sub_rsp_err,
  // manager side (word-aligned addresses only)
  output logic           o_man_vld,
  input  logic           i_man_rdy,
  output logic           o_man_req_lck,
  output logic           o_man_req_ndn,
  output logic           o_man_req_wen,
  output logic [ADR-1:0] o_man_req_adr,
  output logic [SIZ-1:0] o_man_req_siz,
  output logic [BYT-1:0] o_man_req_byt,
  output logic [DAT-1:0] o_man_req_wdt,
  input  logic [DAT-1:0] i_man_rsp_rdt,
  input  logic           i_man_rsp_sts,
  input  logic           i_man_rsp_err
);

  typedef enum logic {
    IDLE   = 1'b0,
    SECOND = 1'b1
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;

  logic [MAX-1:0] w_off;
  logic [MAX+1:0] w_len;
  logic [MAX+1:0] w_end;
  logic           w_cross;
  logic           w_split;
  logic [ADR-1:0] w_adr_base;
  logic [BYT-1:0] w_byt_hi;
  logic [BYT-1:0] w_byt_lo;
  logic [ADR-1:0] r_adr2;
  logic           w_fst0;
  logic           w_spl0;
  logic           w_fst_tap;
  logic           w_spl_tap;
  logic [MAX-1:0] w_off_tap;
  logic [DAT-1:0] r_hld_rdt;
  logic           r_hld_err;

  // crossing detection; MAX+2 bits hold off+len without overflow
  assign w_off      = i_sub_req_adr[MAX-1:0];
  assign w_len      = (MAX+2)'(1) << i_sub_req_siz;
  assign w_end      = {2'b00, w_off} + w_len;
  assign w_cross    = w_end > (MAX+2)'(BYT);
  assign w_split    = i_sub_vld & w_cross;
  assign w_adr_base = {i_sub_req_adr[ADR-1:MAX], {MAX{1'b0}}};

  // lanes at/above the offset go in the first piece, the rest in the second
  always_comb begin
    w_byt_hi = '0;
    w_byt_lo = '0;
    for (int unsigned i = 0; i < BYT; i++) begin
      w_byt_hi[i] = i_sub_req_byt[i] & (MAX'(i) >= w_off);
      w_byt_lo[i] = i_sub_req_byt[i] & (MAX'(i) <  w_off);
    end
  end

  // manager handshakes on the first and second piece of a split
  assign w_fst0 = (r_state == IDLE) & w_split & i_man_rdy;
  assign w_spl0 = (r_state == SECOND) & i_man_rdy;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:   if (w_split && i_man_rdy) w_state_nxt = SECOND;
      SECOND: if (i_man_rdy)            w_state_nxt = IDLE;
    endcase
  end

  // second-piece address, latched on the first-piece handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_adr2 <= '0;
    else if (w_fst0) r_adr2 <= w_adr_base + ADR'(BYT);
  end

  // request outputs: pass-through by default, split pieces otherwise
  always_comb begin
    o_man_vld     = i_sub_vld;
    o_man_req_lck = i_sub_req_lck;
    o_man_req_ndn = i_sub_req_ndn;
    o_man_req_wen = i_sub_req_wen;
    o_man_req_adr = i_sub_req_adr;
    o_man_req_siz = i_sub_req_siz;
    o_man_req_byt = i_sub_req_byt;
    o_man_req_wdt = i_sub_req_wdt;
    o_sub_rdy     = i_man_rdy;
    unique case (r_state)
      IDLE: begin
        if (w_split) begin
          o_man_req_adr = w_adr_base;
          o_man_req_byt = w_byt_hi;
          o_man_req_siz = SIZ'(MAX);
`ifdef TCB_LITE_LIB_MISALIGNED_SPLIT_LCK_EN
          o_man_req_lck = 1'b1;
`endif
          o_sub_rdy     = 1'b0;
        end
      end
      SECOND: begin
        o_man_vld     = 1'b1;
        o_man_req_adr = r_adr2;
        o_man_req_byt = w_byt_lo;
        o_man_req_siz = SIZ'(MAX);
      end
    endcase
  end

  // response-side tracking delayed by DLY; the offset rides along with the
  // second-piece flag so the merge uses the offset of its own request
  generate
    if (DLY == 0) begin : g_dly0
      assign w_fst_tap = w_fst0;
      assign w_spl_tap = w_spl0;
      assign w_off_tap = w_off;
    end else begin : g_dly
      logic [DLY-1:0] r_fst;
      logic [DLY-1:0] r_spl;
      logic [MAX-1:0] r_off [DLY];

      // shift handshake flags and offset through the response delay
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_fst <= '0;
          r_spl <= '0;
          for (int unsigned i = 0; i < DLY; i++) r_off[i] <= '0;
        end else begin
          r_fst[0] <= w_fst0;
          r_spl[0] <= w_spl0;
          r_off[0] <= w_off;
          for (int unsigned i = 1; i < DLY; i++) begin
            r_fst[i] <= r_fst[i-1];
            r_spl[i] <= r_spl[i-1];
            r_off[i] <= r_off[i-1];
          end
        end
      end

      assign w_fst_tap = r_fst[DLY-1];
      assign w_spl_tap = r_spl[DLY-1];
      assign w_off_tap = r_off[DLY-1];
    end
  endgenerate

  // hold the first-piece response until the second piece answers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hld_rdt <= '0;
      r_hld_err <= 1'b0;
    end else if (w_fst_tap) begin
      r_hld_rdt <= i_man_rsp_rdt;
      r_hld_err <= i_man_rsp_err;
    end
  end

  // response merge: upper lanes from the held word, lower lanes live
  always_comb begin
    o_sub_rsp_rdt = i_man_rsp_rdt;
    o_sub_rsp_sts = i_man_rsp_sts;
    o_sub_rsp_err = i_man_rsp_err;
    if (w_spl_tap) begin
      for (int unsigned i = 0; i < BYT; i++) begin
        if (MAX'(i) >= w_off_tap) o_sub_rsp_rdt[8*i +: 8] = r_hld_rdt[8*i +: 8];
      end
      o_sub_rsp_err = r_hld_err | i_man_rsp_err;
    end
  end

  // transfers wider than the data word cannot be split into two pieces
  a_siz_legal: assert property (@(posedge clk) disable iff (rst)
    i_sub_vld |-> (i_sub_req_siz <= SIZ'(MAX)))
    else $error("access size wider than the data word");

endmodule

// File: tb/tb_tcb_lite_lib_misaligned_split.sv
// Testbench for tcb_lite_lib_misaligned_split (BYT=4, DLY=1, ADR=32).
// Reference model: a byte-addressed memory updated by subordinate writes;
// expected manager pieces are derived from which bytes fall in which word.
module tb_tcb_lite_lib_misaligned_split;

  localparam int unsigned DLY = 1;
  localparam int unsigned ADR = 32;
  localparam int unsigned DAT = 32;
`ifdef TCB_LITE_LIB_MISALIGNED_SPLIT_LCK_EN
  localparam bit LCK_EN = 1'b1;
`else
  localparam bit LCK_EN = 1'b0;
`endif

  logic        clk, rst;
  logic        i_sub_vld, o_sub_rdy;
  logic        i_sub_req_lck, i_sub_req_ndn, i_sub_req_wen;
  logic [31:0] i_sub_req_adr;
  logic [1:0]  i_sub_req_siz;
  logic [3:0]  i_sub_req_byt;
  logic [31:0] i_sub_req_wdt;
  logic [31:0] o_sub_rsp_rdt;
  logic        o_sub_rsp_sts, o_sub_rsp_err;
  logic        o_man_vld, i_man_rdy;
  logic        o_man_req_lck, o_man_req_ndn, o_man_req_wen;
  logic [31:0] o_man_req_adr;
  logic [1:0]  o_man_req_siz;
  logic [3:0]  o_man_req_byt;
  logic [31:0] o_man_req_wdt;
  logic [31:0] i_man_rsp_rdt;
  logic        i_man_rsp_sts, i_man_rsp_err;

  tcb_lite_lib_misaligned_split #(.DLY(DLY), .ADR(ADR), .DAT(DAT)) dut (
    .clk(clk), .rst(rst),
    .i_sub_vld(i_sub_vld), .o_sub_rdy(o_sub_rdy),
    .i_sub_req_lck(i_sub_req_lck), .i_sub_req_ndn(i_sub_req_ndn),
    .i_sub_req_wen(i_sub_req_wen), .i_sub_req_adr(i_sub_req_adr),
    .i_sub_req_siz(i_sub_req_siz), .i_sub_req_byt(i_sub_req_byt),
    .i_sub_req_wdt(i_sub_req_wdt),
    .o_sub_rsp_rdt(o_sub_rsp_rdt), .o_sub_rsp_sts(o_sub_rsp_sts),
    .o_sub_rsp_err(o_sub_rsp_err),
    .o_man_vld(o_man_vld), .i_man_rdy(i_man_rdy),
    .o_man_req_lck(o_man_req_lck), .o_man_req_ndn(o_man_req_ndn),
    .o_man_req_wen(o_man_req_wen), .o_man_req_adr(o_man_req_adr),
    .o_man_req_siz(o_man_req_siz), .o_man_req_byt(o_man_req_byt),
    .o_man_req_wdt(o_man_req_wdt),
    .i_man_rsp_rdt(i_man_rsp_rdt), .i_man_rsp_sts(i_man_rsp_sts),
    .i_man_rsp_err(i_man_rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // reference byte memory and the manager's word memory
  logic [7:0]  ref_mem [logic [31:0]];
  logic [31:0] man_mem [logic [31:0]];

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  function automatic logic [31:0] man_rd(input logic [31:0] a);
    return man_mem.exists(a) ? man_mem[a] : 32'h0;
  endfunction

  // manager responder: memory with a one-cycle response, random filler otherwise
  logic        err_en = 1'b0;
  logic [31:0] err_adr = 32'h0;
  logic        m_pend;
  logic [31:0] m_dat;
  logic        m_err;

  initial begin
    i_man_rsp_rdt = '0;
    i_man_rsp_sts = 1'b0;
    i_man_rsp_err = 1'b0;
    forever begin
      @(negedge clk);
      m_pend = 1'b0;
      if (!rst && o_man_vld && i_man_rdy) begin
        if (o_man_req_wen) begin
          logic [31:0] w;
          w = man_rd({o_man_req_adr[31:2], 2'b00});
          for (int b = 0; b < 4; b++)
            if (o_man_req_byt[b]) w[8*b +: 8] = o_man_req_wdt[8*b +: 8];
          man_mem[{o_man_req_adr[31:2], 2'b00}] = w;
        end else begin
          m_pend = 1'b1;
          m_dat  = man_rd({o_man_req_adr[31:2], 2'b00});
          m_err  = err_en && ({o_man_req_adr[31:2], 2'b00} == err_adr);
        end
      end
      @(posedge clk);
      #1;
      i_man_rsp_rdt = m_pend ? m_dat : $urandom;
      i_man_rsp_err = m_pend ? m_err : 1'b0;
      i_man_rsp_sts = m_pend ? 1'b0 : 1'($urandom);
    end
  end

  // pending subordinate read response expected in the next cycle
  logic        pend = 1'b0;
  logic [31:0] pend_dat, pend_mask;
  logic        pend_err;
  logic [31:0] last_rdt = '0;
  logic        last_err = 1'b0;

  task automatic check_rsp();
    if (pend) begin
      last_rdt = o_sub_rsp_rdt;
      last_err = o_sub_rsp_err;
      checks++;
      if ((o_sub_rsp_rdt & pend_mask) !== (pend_dat & pend_mask))
        $display("FAIL rsp_rdt: got %h expected %h (mask %h)", o_sub_rsp_rdt, pend_dat, pend_mask);
      else passed++;
      checks++;
      if ({o_sub_rsp_err, o_sub_rsp_sts} !== {pend_err, 1'b0})
        $display("FAIL rsp_err_sts: got %b expected %b", {o_sub_rsp_err, o_sub_rsp_sts}, {pend_err, 1'b0});
      else passed++;
      pend = 1'b0;
    end
  endtask

  // one subordinate access; stall<0 means random man.rdy, otherwise
  // man.rdy is low for 'stall' cycles on each piece
  task automatic do_access(input logic [31:0] adr, input int siz, input logic wen,
                           input logic lck, input logic [31:0] wdt, input int stall,
                           output int ncyc);
    int          off, len, np, p, waitc;
    logic [3:0]  byt, hi;
    logic [31:0] padr [2];
    logic [3:0]  pbyt [2];
    logic [1:0]  psiz [2];
    logic        plck [2];
    logic [31:0] edat, emask;
    logic        eerr, ndn, rdy, done;
    off = int'(adr[1:0]);
    len = 1 << siz;
    byt = '0; edat = '0; emask = '0;
    for (int k = 0; k < len; k++) begin
      int ln;
      ln = (off + k) % 4;
      byt[ln] = 1'b1;
      emask[8*ln +: 8] = 8'hFF;
      edat[8*ln +: 8]  = ref_rd(adr + 32'(k));
    end
    hi = 4'hF << off;
    if (off + len > 4) begin
      np = 2;
      padr[0] = {adr[31:2], 2'b00}; pbyt[0] = byt & hi;  psiz[0] = 2'd2; plck[0] = LCK_EN ? 1'b1 : lck;
      padr[1] = padr[0] + 32'd4;    pbyt[1] = byt & ~hi; psiz[1] = 2'd2; plck[1] = lck;
    end else begin
      np = 1;
      padr[0] = adr; pbyt[0] = byt; psiz[0] = 2'(siz); plck[0] = lck;
      padr[1] = '0;  pbyt[1] = '0;  psiz[1] = '0;      plck[1] = 1'b0;
    end
    eerr = err_en && (({padr[0][31:2], 2'b00} == err_adr) || (np == 2 && padr[1] == err_adr));
    ndn = 1'($urandom);
    i_sub_vld = 1'b1; i_sub_req_adr = adr; i_sub_req_siz = 2'(siz); i_sub_req_byt = byt;
    i_sub_req_wen = wen; i_sub_req_lck = lck; i_sub_req_ndn = ndn; i_sub_req_wdt = wdt;
    p = 0; waitc = 0; ncyc = 0; done = 1'b0;
    while (!done) begin
      rdy = (stall < 0) ? ($urandom_range(0, 2) != 0) : (waitc >= stall);
      i_man_rdy = rdy;
      @(negedge clk);
      check_rsp();
      ncyc++;
      checks++;
      if ({o_man_vld, o_man_req_adr} !== {1'b1, padr[p]})
        $display("FAIL man_vld_adr piece%0d: got %b/%h expected 1/%h", p, o_man_vld, o_man_req_adr, padr[p]);
      else passed++;
      checks++;
      if (o_man_req_byt !== pbyt[p])
        $display("FAIL man_byt piece%0d: got %b expected %b", p, o_man_req_byt, pbyt[p]);
      else passed++;
      checks++;
      if ({o_man_req_siz, o_man_req_lck, o_man_req_wen, o_man_req_ndn} !== {psiz[p], plck[p], wen, ndn})
        $display("FAIL man_ctl piece%0d: got siz/lck/wen/ndn %b expected %b", p,
                 {o_man_req_siz, o_man_req_lck, o_man_req_wen, o_man_req_ndn}, {psiz[p], plck[p], wen, ndn});
      else passed++;
      checks++;
      if (o_man_req_wdt !== wdt)
        $display("FAIL man_wdt piece%0d: got %h expected %h", p, o_man_req_wdt, wdt);
      else passed++;
      checks++;
      if (o_sub_rdy !== ((p == np - 1) ? rdy : 1'b0))
        $display("FAIL sub_rdy piece%0d: got %b expected %b", p, o_sub_rdy, (p == np - 1) ? rdy : 1'b0);
      else passed++;
      if (rdy) begin
        if (p == np - 1) done = 1'b1;
        else begin p++; waitc = 0; end
      end else waitc++;
      if (!done && ncyc >= 200) begin
        checks++;
        $display("FAIL access_timeout: got %0d cycles expected completion", ncyc);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    i_sub_vld = 1'b0;
    if (wen) begin
      for (int k = 0; k < len; k++) ref_mem[adr + 32'(k)] = wdt[8*((off + k) % 4) +: 8];
    end else begin
      pend = 1'b1; pend_dat = edat; pend_mask = emask; pend_err = eerr;
    end
  endtask

  task automatic idle_cycle();
    i_sub_vld = 1'b0;
    i_man_rdy = 1'($urandom);
    @(negedge clk);
    check_rsp();
    checks++;
    if (o_man_vld !== 1'b0) $display("FAIL idle_man_vld: got %b expected 0", o_man_vld);
    else passed++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_sub_vld = 1'b0; i_man_rdy = 1'b1;
    i_sub_req_lck = 0; i_sub_req_ndn = 0; i_sub_req_wen = 0;
    i_sub_req_adr = '0; i_sub_req_siz = '0; i_sub_req_byt = '0; i_sub_req_wdt = '0;
    @(negedge clk);
    checks++;
    if ({o_man_vld, o_sub_rdy} !== 2'b01) $display("FAIL reset_vld_rdy: got %b expected 01", {o_man_vld, o_sub_rdy});
    else passed++;
    checks++;
    if (o_sub_rsp_rdt !== i_man_rsp_rdt) $display("FAIL reset_rsp_mirror: got %h expected %h", o_sub_rsp_rdt, i_man_rsp_rdt);
    else passed++;
    i_man_rdy = 1'b0;
    #1;
    checks++;
    if (o_sub_rdy !== 1'b0) $display("FAIL reset_rdy_follow: got %b expected 0", o_sub_rdy);
    else passed++;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (o_man_vld !== 1'b0) $display("FAIL post_reset_vld: got %b expected 0", o_man_vld);
    else passed++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_passthrough();
    int n;
    do_access(32'h10, 2, 1'b1, 1'b0, 32'h11223344, 2, n);
    do_access(32'h10, 2, 1'b0, 1'b0, 32'h0, 0, n);
    checks++;
    if (n !== 1) $display("FAIL pass_latency: got %0d cycles expected 1", n);
    else passed++;
    do_access(32'h21, 0, 1'b1, 1'b1, $urandom, 0, n);
    do_access(32'h22, 1, 1'b0, 1'b0, 32'h0, 1, n);
    idle_cycle();
  endtask

  task automatic test_split_write();
    int n;
    do_access(32'h13, 2, 1'b1, 1'b0, 32'hA1B2C3D4, 0, n);
    checks++;
    if (n !== 2) $display("FAIL split_write_cycles: got %0d expected 2", n);
    else passed++;
    do_access(32'h13, 2, 1'b0, 1'b0, 32'h0, 0, n);
    idle_cycle();
  endtask

  task automatic test_read_merge();
    int n;
    do_access(32'h08, 2, 1'b1, 1'b0, 32'hAA000000, 0, n);
    do_access(32'h0C, 2, 1'b1, 1'b0, 32'h000000BB, 0, n);
    do_access(32'h0B, 1, 1'b0, 1'b0, 32'h0, 0, n);
    idle_cycle();
    checks++;
    if ((last_rdt & 32'hFF0000FF) !== 32'hAA0000BB)
      $display("FAIL merge_rdt: got %h expected AA0000BB", last_rdt & 32'hFF0000FF);
    else passed++;
  endtask

  task automatic test_stall();
    int n;
    do_access(32'h17, 2, 1'b1, 1'b0, 32'h5A6B7C8D, 3, n);
    checks++;
    if (n !== 8) $display("FAIL stall_cycles: got %0d expected 8", n);
    else passed++;
    do_access(32'h17, 2, 1'b0, 1'b0, 32'h0, 3, n);
    idle_cycle();
  endtask

  task automatic test_err_lck();
    int n;
    err_en = 1'b1; err_adr = 32'h30;
    do_access(32'h32, 2, 1'b0, 1'b0, 32'h0, 0, n);
    idle_cycle();
    checks++;
    if (last_err !== 1'b1) $display("FAIL piece1_err: got %b expected 1", last_err);
    else passed++;
    err_en = 1'b0;
  endtask

  task automatic test_wrap();
    int n;
    do_access(32'hFFFFFFFE, 2, 1'b1, 1'b0, 32'hC0FFEE11, 0, n);
    do_access(32'hFFFFFFFE, 2, 1'b0, 1'b0, 32'h0, 1, n);
    idle_cycle();
  endtask

  task automatic test_reset_mid();
    int n;
    i_sub_vld = 1'b1; i_sub_req_adr = 32'hFFFFFFFE; i_sub_req_siz = 2'd2;
    i_sub_req_byt = 4'hF; i_sub_req_wen = 1'b0; i_sub_req_lck = 1'b0; i_man_rdy = 1'b1;
    @(negedge clk);
    checks++;
    if (o_man_req_adr !== 32'hFFFFFFFC) $display("FAIL rm_piece1_adr: got %h expected FFFFFFFC", o_man_req_adr);
    else passed++;
    @(posedge clk);
    #1 i_man_rdy = 1'b0;
    @(negedge clk);
    checks++;
    if (o_man_req_adr !== 32'h0) $display("FAIL rm_piece2_adr: got %h expected 00000000", o_man_req_adr);
    else passed++;
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({o_man_req_adr, o_sub_rdy} !== {32'hFFFFFFFC, 1'b0})
      $display("FAIL rm_back_to_idle: got %h/%b expected FFFFFFFC/0", o_man_req_adr, o_sub_rdy);
    else passed++;
    i_sub_vld = 1'b0;
    #1;
    checks++;
    if (o_man_vld !== 1'b0) $display("FAIL rm_vld_low: got %b expected 0", o_man_vld);
    else passed++;
    @(posedge clk);
    #1 rst = 1'b0;
    pend = 1'b0;
    @(negedge clk);
    checks++;
    if ({o_sub_rsp_rdt, o_sub_rsp_err} !== {i_man_rsp_rdt, i_man_rsp_err})
      $display("FAIL rm_no_merge: got %h expected %h", o_sub_rsp_rdt, i_man_rsp_rdt);
    else passed++;
    @(posedge clk);
    #1;
    do_access(32'hFFFFFFFE, 2, 1'b0, 1'b0, 32'h0, 0, n);
    idle_cycle();
  endtask

  task automatic test_back_to_back();
    int n;
    logic [31:0] adrs [6] = '{32'h41, 32'h43, 32'h44, 32'h46, 32'h47, 32'h48};
    int          sizs [6] = '{1, 1, 2, 2, 0, 2};
    int          exps [6] = '{1, 2, 1, 2, 1, 1};
    for (int i = 0; i < 6; i++) begin
      do_access(adrs[i], sizs[i], 1'(i % 2), 1'b0, $urandom, 0, n);
      checks++;
      if (n !== exps[i]) $display("FAIL b2b_cycles[%0d]: got %0d expected %0d", i, n, exps[i]);
      else passed++;
    end
    idle_cycle();
  endtask

  task automatic test_random();
    int n;
    logic [31:0] a;
    for (int i = 0; i < 60; i++) begin
      a = ($urandom_range(0, 4) == 0) ? (32'hFFFFFFF8 + 32'($urandom_range(0, 7)))
                                      : (32'h100 + 32'($urandom_range(0, 31)));
      do_access(a, int'($urandom_range(0, 2)), 1'($urandom), 1'($urandom), $urandom, -1, n);
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end
    idle_cycle();
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_split_write();
    test_read_merge();
    test_stall();
    test_err_lck();
    test_wrap();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no completion expected finish");
    $fatal(1, "simulation time limit");
  end

endmodule
